// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner: board switch front end for the cpu core.
// Each switch is synchronised and debounced independently; a debounced rising
// edge on SW8 captures SW[7:0] as a byte. The cpu takes the byte over a
// valid/ack handshake, one byte per press. A press that arrives while a byte
// is still waiting raises a sticky overrun flag and is dropped.
// All state uses a synchronous active-low reset.

module sw_input_conditioner #(
  parameter int unsigned DB_COUNT = 50000,
  // Derived from DB_COUNT; leave at its default.
  parameter int unsigned CNT_W    = $clog2(DB_COUNT + 1)
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic [9:0] SW_raw,
  output logic [9:0] SW_db,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       overrun
);

  localparam int unsigned NumSw = 10;

  // Last count before a debounced bit takes the new level.
  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_COUNT - 1);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StPresented = 2'd1,
    StWaitRel   = 2'd2
  } state_e;

  logic [NumSw-1:0] sync1_q;
  logic [NumSw-1:0] sync2_q;
  logic [CNT_W-1:0] cnt_q [NumSw];
  logic             sw8_q;
  logic             press;
  state_e           state_q;

  // Two-flop synchroniser for every raw switch.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= SW_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: a bit follows its synchronised input only after the
  // input has disagreed with it for DB_COUNT consecutive cycles.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      SW_db <= '0;
      for (int i = 0; i < NumSw; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumSw; i++) begin
        if (sync2_q[i] != SW_db[i]) begin
          if (cnt_q[i] == DbLast) begin
            SW_db[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          // Any agreement restarts the window, so short glitches never land.
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Delayed copy of the debounced SW8 for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      sw8_q <= 1'b0;
    end else begin
      sw8_q <= SW_db[8];
    end
  end

  // A switch held high through reset counts as a press once it debounces,
  // because sw8_q starts at 0.
  assign press = SW_db[8] & ~sw8_q;

  // Handshake FSM with registered byte, valid and overrun outputs.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q    <= StIdle;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (press) begin
            data_out   <= SW_db[7:0];
            data_valid <= 1'b1;
            state_q    <= StPresented;
          end
        end
        StPresented: begin
          // A second press never replaces the pending byte; it only flags.
          if (press) begin
            overrun <= 1'b1;
          end
          if (data_ack) begin
            data_valid <= 1'b0;
            state_q    <= SW_db[8] ? StWaitRel : StIdle;
          end
        end
        StWaitRel: begin
          if (!SW_db[8]) begin
            state_q <= StIdle;
          end
        end
        default: begin
          data_valid <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner with DB_COUNT=4: reset, glitch
// rejection, handshake, overrun, simultaneous press/ack and reset mid-transfer.

module tb_sw_input_conditioner;

  localparam int unsigned DbCount = 4;

  localparam logic [31:0] StIdleV      = 32'd0;
  localparam logic [31:0] StPresentedV = 32'd1;
  localparam logic [31:0] StWaitRelV   = 32'd2;

  logic       clk;
  logic       nReset;
  logic [9:0] SW_raw;
  logic [9:0] SW_db;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ack;
  logic       overrun;

  int n_checks;
  int n_failures;

  sw_input_conditioner #(
    .DB_COUNT(DbCount)
  ) dut (
    .clk       (clk),
    .nReset    (nReset),
    .SW_raw    (SW_raw),
    .SW_db     (SW_db),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ack  (data_ack),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; outputs are settled 1 time unit after the edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] fsm_state();
    return 32'(dut.state_q);
  endfunction

  logic seen;

  initial begin
    n_checks   = 0;
    n_failures = 0;
    nReset     = 1'b0;
    SW_raw     = 10'h3FF;
    data_ack   = 1'b0;

    // 1. Reset with all switches high, then one press from the held SW8.
    step(3);
    check("rst_sw_db", 32'(SW_db), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    nReset = 1'b1;
    step(5);
    check("db_before_latency", 32'(SW_db), 32'h0);
    step(1);
    check("db_at_latency", 32'(SW_db), 32'h3FF);
    check("valid_not_yet", 32'(data_valid), 32'h0);
    step(1);
    check("rst_press_valid", 32'(data_valid), 32'h1);
    check("rst_press_data", 32'(data_out), 32'hFF);
    data_ack = 1'b1;
    step(1);
    data_ack = 1'b0;
    check("rst_ack_valid", 32'(data_valid), 32'h0);
    check("rst_ack_state", fsm_state(), StWaitRelV);
    SW_raw = 10'h000;
    step(DbCount + 2);
    check("release_db", 32'(SW_db), 32'h0);
    step(1);
    check("release_idle", fsm_state(), StIdleV);

    // 2. Glitch rejection and exact latency on bit 3.
    SW_raw = 10'h008;
    step(3);
    SW_raw = 10'h000;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      seen = seen | SW_db[3];
    end
    check("glitch3_rejected", 32'(seen), 32'h0);
    SW_raw = 10'h008;
    step(5);
    check("pulse6_not_yet", 32'(SW_db[3]), 32'h0);
    step(1);
    check("pulse6_db", 32'(SW_db[3]), 32'h1);
    SW_raw = 10'h000;
    step(8);
    check("pulse6_fall", 32'(SW_db), 32'h0);

    // 3. Normal handshake; no second byte after release.
    SW_raw = 10'h0A5;
    step(8);
    SW_raw = 10'h1A5;
    step(6);
    check("hs_valid_not_yet", 32'(data_valid), 32'h0);
    step(1);
    check("hs_valid", 32'(data_valid), 32'h1);
    check("hs_data", 32'(data_out), 32'hA5);
    check("hs_sw_db", 32'(SW_db), 32'h1A5);
    step(3);
    check("hs_hold_data", 32'(data_out), 32'hA5);
    check("hs_hold_state", fsm_state(), StPresentedV);
    data_ack = 1'b1;
    step(1);
    data_ack = 1'b0;
    check("hs_ack_valid", 32'(data_valid), 32'h0);
    check("hs_wait_rel", fsm_state(), StWaitRelV);
    SW_raw = 10'h0A5;
    step(DbCount + 3);
    check("hs_idle", fsm_state(), StIdleV);
    step(10);
    check("hs_no_second", 32'(data_valid), 32'h0);
    check("hs_no_overrun", 32'(overrun), 32'h0);

    // 4. Overrun: second press while the first byte is unconsumed.
    SW_raw = 10'h13C;
    step(7);
    check("ov_first_valid", 32'(data_valid), 32'h1);
    check("ov_first_data", 32'(data_out), 32'h3C);
    SW_raw = 10'h03C;
    step(8);
    SW_raw = 10'h181;
    step(6);
    check("ov_not_yet", 32'(overrun), 32'h0);
    step(1);
    check("ov_set", 32'(overrun), 32'h1);
    check("ov_data_kept", 32'(data_out), 32'h3C);
    check("ov_still_valid", 32'(data_valid), 32'h1);
    data_ack = 1'b1;
    step(1);
    data_ack = 1'b0;
    check("ov_ack_valid", 32'(data_valid), 32'h0);
    check("ov_sticky", 32'(overrun), 32'h1);
    check("ov_wait_rel", fsm_state(), StWaitRelV);
    SW_raw = 10'h000;
    step(8);
    check("ov_idle", fsm_state(), StIdleV);

    // Clear overrun through reset before the next case.
    nReset = 1'b0;
    step(1);
    nReset = 1'b1;
    check("ov_cleared", 32'(overrun), 32'h0);

    // 5. Press and ack land in the same cycle.
    SW_raw = 10'h155;
    step(7);
    check("sim_first_valid", 32'(data_valid), 32'h1);
    SW_raw = 10'h055;
    step(8);
    SW_raw = 10'h1AA;
    step(6);
    data_ack = 1'b1;
    step(1);
    data_ack = 1'b0;
    check("sim_valid", 32'(data_valid), 32'h0);
    check("sim_overrun", 32'(overrun), 32'h1);
    check("sim_data_kept", 32'(data_out), 32'h55);
    check("sim_wait_rel", fsm_state(), StWaitRelV);
    step(5);
    check("sim_discarded", 32'(data_valid), 32'h0);

    // 6. Reset while a byte is presented; held SW8 then re-presents once.
    SW_raw = 10'h000;
    step(8);
    SW_raw = 10'h1F0;
    step(7);
    check("mid_valid", 32'(data_valid), 32'h1);
    nReset = 1'b0;
    step(1);
    check("mid_rst_valid", 32'(data_valid), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    check("mid_rst_db", 32'(SW_db), 32'h0);
    check("mid_rst_state", fsm_state(), StIdleV);
    nReset = 1'b1;
    step(7);
    check("post_rst_valid", 32'(data_valid), 32'h1);
    check("post_rst_data", 32'(data_out), 32'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
